// File: rtl/dp_tap_ctrl.sv
// dp_tap_ctrl: IEEE 1149.1 TAP controller and instruction register for the RISC-V debug
// transport. Drives the DR strobes and bsr_sel of dp_mux_dr, and muxes the IR shift path
// with the returned DR serial data onto tdo.
//
// Ports:
//   tck         in   TAP clock (only clock)
//   trstn       in   asynchronous active-low reset
//   tms         in   test mode select, sampled on posedge tck
//   tdi         in   test data in, sampled on posedge tck
//   tdo         out  test data out, updated on negedge tck
//   tdo_oe      out  tdo output enable, high while shifting IR or DR
//   dr_sdo      in   serial out of the selected DR
//   capture_dr  out  state is CAPTURE_DR
//   shift_dr    out  state is SHIFT_DR
//   clk_dr      out  DR clock enable (capture_dr | shift_dr), qualifies tck
//   update_dr   out  state is UPDATE_DR
//   bsr_sel     out  DR select: 0 IDCODE, 1 DTMCS, 2 DMI, 3 BYPASS
//   tap_state   out  current TAP state encoding
module dp_tap_ctrl #(
    parameter int unsigned     IR_W      = 5,
    parameter logic [IR_W-1:0] IR_IDCODE = 5'h01,
    parameter logic [IR_W-1:0] IR_DTMCS  = 5'h10,
    parameter logic [IR_W-1:0] IR_DMI    = 5'h11,
    parameter logic [IR_W-1:0] IR_BYPASS = 5'h1F
) (
    input  logic       tck,
    input  logic       trstn,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_oe,
    input  logic       dr_sdo,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       clk_dr,
    output logic       update_dr,
    output logic [3:0] bsr_sel,
    output logic [3:0] tap_state
);

    // Encodings match the 1149.1 state table so tap_state is directly comparable.
    typedef enum logic [3:0] {
        StTlr   = 4'hF,
        StRti   = 4'hC,
        StSelDr = 4'h7,
        StCapDr = 4'h6,
        StShDr  = 4'h2,
        StEx1Dr = 4'h1,
        StPaDr  = 4'h3,
        StEx2Dr = 4'h0,
        StUpdDr = 4'h5,
        StSelIr = 4'h4,
        StCapIr = 4'hE,
        StShIr  = 4'hA,
        StEx1Ir = 4'h9,
        StPaIr  = 4'hB,
        StEx2Ir = 4'h8,
        StUpdIr = 4'hD
    } tap_state_e;

    tap_state_e state_q, state_d;

    logic [IR_W-1:0] ir_shift_q;
    logic [IR_W-1:0] ir_q;

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            state_q <= StTlr;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:   state_d = tms ? StTlr   : StRti;
            StRti:   state_d = tms ? StSelDr : StRti;
            StSelDr: state_d = tms ? StSelIr : StCapDr;
            StCapDr: state_d = tms ? StEx1Dr : StShDr;
            StShDr:  state_d = tms ? StEx1Dr : StShDr;
            StEx1Dr: state_d = tms ? StUpdDr : StPaDr;
            StPaDr:  state_d = tms ? StEx2Dr : StPaDr;
            StEx2Dr: state_d = tms ? StUpdDr : StShDr;
            StUpdDr: state_d = tms ? StSelDr : StRti;
            StSelIr: state_d = tms ? StTlr   : StCapIr;
            StCapIr: state_d = tms ? StEx1Ir : StShIr;
            StShIr:  state_d = tms ? StEx1Ir : StShIr;
            StEx1Ir: state_d = tms ? StUpdIr : StPaIr;
            StPaIr:  state_d = tms ? StEx2Ir : StPaIr;
            StEx2Ir: state_d = tms ? StUpdIr : StShIr;
            StUpdIr: state_d = tms ? StSelDr : StRti;
        endcase
    end

    // Moore decodes of the registered state: stable for the whole tck cycle.
    always_comb begin
        capture_dr = (state_q == StCapDr);
        shift_dr   = (state_q == StShDr);
        clk_dr     = (state_q == StCapDr) || (state_q == StShDr);
        update_dr  = (state_q == StUpdDr);
        tap_state  = state_q;
    end

    // ------------------------------------------------------------------
    // Instruction shift register and latch
    // ------------------------------------------------------------------
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            ir_shift_q <= '0;
            ir_q       <= IR_IDCODE;
        end else begin
            if (state_q == StCapIr) begin
                // Fixed 01 capture pattern lets the host verify IR-chain integrity.
                ir_shift_q <= {{(IR_W-2){1'b0}}, 2'b01};
            end else if (state_q == StShIr) begin
                ir_shift_q <= {tdi, ir_shift_q[IR_W-1:1]};
            end

            if (state_q == StUpdIr) begin
                ir_q <= ir_shift_q;
            end else if (state_q == StTlr) begin
                ir_q <= IR_IDCODE;
            end
        end
    end

    // Unknown opcodes, including all-zero, fall back to the 1-bit bypass register.
    always_comb begin
        bsr_sel = 4'd3;
        case (ir_q)
            IR_IDCODE: bsr_sel = 4'd0;
            IR_DTMCS:  bsr_sel = 4'd1;
            IR_DMI:    bsr_sel = 4'd2;
            IR_BYPASS: bsr_sel = 4'd3;
            default:   bsr_sel = 4'd3;
        endcase
    end

    // ------------------------------------------------------------------
    // TDO path, launched on the falling edge so it is stable for the
    // receiver's next rising edge.
    // ------------------------------------------------------------------
    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else if (state_q == StShIr) begin
            tdo    <= ir_shift_q[0];
            tdo_oe <= 1'b1;
        end else if (state_q == StShDr) begin
            tdo    <= dr_sdo;
            tdo_oe <= 1'b1;
        end else begin
            tdo_oe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Self-checking bench for dp_tap_ctrl: directed scenarios plus a random tms/tdi walk,
// all compared against a table-driven reference model of the TAP.
module tb_dp_tap_ctrl;

    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SEL_DR = 4'h7, S_CAP_DR = 4'h6;
    localparam logic [3:0] S_SH_DR = 4'h2, S_EX1_DR = 4'h1, S_PA_DR = 4'h3, S_EX2_DR = 4'h0;
    localparam logic [3:0] S_UPD_DR = 4'h5, S_SEL_IR = 4'h4, S_CAP_IR = 4'hE, S_SH_IR = 4'hA;
    localparam logic [3:0] S_EX1_IR = 4'h9, S_PA_IR = 4'hB, S_EX2_IR = 4'h8, S_UPD_IR = 4'hD;

    logic       tck, trstn, tms, tdi, dr_sdo;
    logic       tdo, tdo_oe, capture_dr, shift_dr, clk_dr, update_dr;
    logic [3:0] bsr_sel, tap_state;

    int checks = 0;
    int errors = 0;

    dp_tap_ctrl dut (
        .tck        (tck),
        .trstn      (trstn),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_oe     (tdo_oe),
        .dr_sdo     (dr_sdo),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .clk_dr     (clk_dr),
        .update_dr  (update_dr),
        .bsr_sel    (bsr_sel),
        .tap_state  (tap_state)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // ---------------- reference model ----------------
    logic [3:0] nx0 [16];
    logic [3:0] nx1 [16];
    logic [3:0] m_state;
    logic [4:0] m_ir, m_irsh;
    logic       m_tdo, m_oe;

    always @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            m_state = S_TLR;
            m_ir    = 5'h01;
            m_irsh  = 5'h00;
        end else begin
            if (m_state == S_CAP_IR) m_irsh = 5'd1;
            else if (m_state == S_SH_IR) m_irsh = (m_irsh >> 1) + (tdi ? 5'd16 : 5'd0);
            if (m_state == S_UPD_IR) m_ir = m_irsh;
            else if (m_state == S_TLR) m_ir = 5'h01;
            m_state = tms ? nx1[m_state] : nx0[m_state];
        end
    end

    always @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            m_tdo = 1'b0;
            m_oe  = 1'b0;
        end else if (m_state == S_SH_IR) begin
            m_tdo = m_irsh[0];
            m_oe  = 1'b1;
        end else if (m_state == S_SH_DR) begin
            m_tdo = dr_sdo;
            m_oe  = 1'b1;
        end else begin
            m_oe = 1'b0;
        end
    end

    function automatic logic [3:0] exp_sel(input logic [4:0] op);
        if (op == 5'h01) return 4'd0;
        if (op == 5'h10) return 4'd1;
        if (op == 5'h11) return 4'd2;
        return 4'd3;
    endfunction

    // ---------------- drivers ----------------
    task automatic step(input logic t_tms, input logic t_tdi);
        tms = t_tms;
        tdi = t_tdi;
        @(posedge tck);
        #1;
    endtask

    // From RTI/TLR: scan val into IR LSB first; returns tdo bits seen; ends in UPD_IR.
    task automatic load_ir(input logic [4:0] val, output logic [4:0] bits);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge tck);
            #1;
            bits[i] = tdo;
            step(i == 4, val[i]);
        end
        step(1'b1, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [4:0] ob;
        logic       upd_seen;
        load_ir(5'h11, ob);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        dr_sdo = 1'b1;
        step(1'b0, 1'b0);
        checks++;
        if (shift_dr !== 1'b1) begin
            errors++; $display("FAIL reset_pre_shift: shift_dr=%b want 1", shift_dr);
        end
        @(negedge tck);
        #1;
        checks++;
        if (tdo !== 1'b1 || tdo_oe !== 1'b1) begin
            errors++; $display("FAIL reset_pre_tdo: tdo=%b oe=%b want 1 1", tdo, tdo_oe);
        end
        #2;
        trstn = 1'b0;
        #1;
        checks++;
        if (tap_state !== S_TLR) begin
            errors++; $display("FAIL reset_state: got %h want %h", tap_state, S_TLR);
        end
        checks++;
        if (bsr_sel !== 4'd0) begin
            errors++; $display("FAIL reset_bsr_sel: got %0d want 0", bsr_sel);
        end
        checks++;
        if ({capture_dr, shift_dr, clk_dr, update_dr, tdo, tdo_oe} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {capture_dr, shift_dr, clk_dr, update_dr, tdo, tdo_oe});
        end
        upd_seen = 1'b0;
        repeat (3) begin
            tms = 1'b0;
            @(posedge tck);
            #1;
            upd_seen = upd_seen | update_dr | capture_dr | shift_dr | clk_dr;
        end
        checks++;
        if (upd_seen !== 1'b0 || tap_state !== S_TLR || bsr_sel !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: strobe=%b state=%h sel=%0d want 0 F 0",
                     upd_seen, tap_state, bsr_sel);
        end
        trstn = 1'b1;
    endtask

    task automatic test_ir_load();
        logic [4:0] ob;
        load_ir(5'h11, ob);
        checks++;
        if (ob !== 5'h01) begin
            errors++; $display("FAIL ir_capture_bits: got %b want 00001", ob);
        end
        checks++;
        if (tap_state !== S_UPD_IR || bsr_sel !== 4'd0) begin
            errors++;
            $display("FAIL ir_upd_cycle: state=%h sel=%0d want D 0", tap_state, bsr_sel);
        end
        step(1'b0, 1'b0);
        checks++;
        if (tap_state !== S_RTI || bsr_sel !== 4'd2) begin
            errors++;
            $display("FAIL ir_after_upd: state=%h sel=%0d want C 2", tap_state, bsr_sel);
        end
        checks++;
        if (m_ir !== 5'h11) begin
            errors++; $display("FAIL ir_model: got %h want 11", m_ir);
        end
    endtask

    task automatic test_unknown_opcode();
        logic [4:0] ops [9];
        logic [4:0] ob;
        ops[0] = 5'h05; ops[1] = 5'h10; ops[2] = 5'h00; ops[3] = 5'h1F; ops[4] = 5'h01;
        ops[5] = 5'h11;
        for (int i = 6; i < 9; i++) ops[i] = 5'($urandom_range(0, 31));
        for (int i = 0; i < 9; i++) begin
            load_ir(ops[i], ob);
            step(1'b0, 1'b0);
            checks++;
            if (bsr_sel !== exp_sel(ops[i]) || ob !== 5'h01) begin
                errors++;
                $display("FAIL opcode_%h: sel=%0d cap=%b want sel=%0d cap=00001",
                         ops[i], bsr_sel, ob, exp_sel(ops[i]));
            end
        end
    endtask

    task automatic test_dr_scan();
        logic [4:0]  ob;
        logic [19:0] seq;
        int          n_cap, n_sh, n_clk, n_upd;
        seq = 20'b0110_0001_0100_0000_0001;
        n_cap = 0; n_sh = 0; n_clk = 0; n_upd = 0;
        load_ir(5'h11, ob);
        step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(seq[i], 1'($urandom_range(0, 1)));
            dr_sdo = 1'($urandom_range(0, 1));
            n_cap += int'(capture_dr);
            n_sh  += int'(shift_dr);
            n_clk += int'(clk_dr);
            n_upd += int'(update_dr);
            checks++;
            if (tap_state !== m_state) begin
                errors++; $display("FAIL dr_state_%0d: got %h want %h", i, tap_state, m_state);
            end
            @(negedge tck);
            #1;
            checks++;
            if (m_state == S_SH_DR) begin
                if (tdo !== dr_sdo || tdo_oe !== 1'b1) begin
                    errors++;
                    $display("FAIL dr_tdo_%0d: tdo=%b oe=%b want %b 1", i, tdo, tdo_oe, dr_sdo);
                end
            end else if (tdo_oe !== 1'b0) begin
                errors++; $display("FAIL dr_oe_%0d: oe=%b want 0", i, tdo_oe);
            end
        end
        checks++;
        if (n_cap != 1 || n_sh != 12 || n_clk != 13 || n_upd != 1) begin
            errors++;
            $display("FAIL dr_strobe_counts: cap=%0d sh=%0d clk=%0d upd=%0d want 1 12 13 1",
                     n_cap, n_sh, n_clk, n_upd);
        end
        checks++;
        if (tap_state !== S_RTI) begin
            errors++; $display("FAIL dr_end_state: got %h want C", tap_state);
        end
    endtask

    task automatic test_tms_reset();
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(3, 20);
            for (int i = 0; i < n; i++) begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                checks++;
                if (tap_state !== m_state) begin
                    errors++;
                    $display("FAIL walk_%0d_%0d: got %h want %h", r, i, tap_state, m_state);
                end
            end
            repeat (5) step(1'b1, 1'b0);
            checks++;
            if (tap_state !== S_TLR) begin
                errors++; $display("FAIL tms_reset_%0d: got %h want F", r, tap_state);
            end
            step(1'b0, 1'b0);
            checks++;
            if (tap_state !== S_RTI) begin
                errors++; $display("FAIL tms_reset_rti_%0d: got %h want C", r, tap_state);
            end
        end
    endtask

    task automatic test_tlr_side_effect();
        logic [4:0] ob;
        logic       upd_ir_seen;
        load_ir(5'h11, ob);
        step(1'b0, 1'b0);
        checks++;
        if (bsr_sel !== 4'd2) begin
            errors++; $display("FAIL tlr_pre_sel: got %0d want 2", bsr_sel);
        end
        upd_ir_seen = 1'b0;
        repeat (5) begin
            step(1'b1, 1'b0);
            if (tap_state === S_UPD_IR) upd_ir_seen = 1'b1;
        end
        checks++;
        if (tap_state !== S_TLR || bsr_sel !== 4'd0 || upd_ir_seen !== 1'b0) begin
            errors++;
            $display("FAIL tlr_side_effect: state=%h sel=%0d upd_ir=%b want F 0 0",
                     tap_state, bsr_sel, upd_ir_seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            dr_sdo = 1'($urandom_range(0, 1));
            checks++;
            if (tap_state !== m_state || bsr_sel !== exp_sel(m_ir)) begin
                errors++;
                $display("FAIL rand_state_%0d: state=%h sel=%0d want %h %0d",
                         i, tap_state, bsr_sel, m_state, exp_sel(m_ir));
            end
            checks++;
            if ({capture_dr, shift_dr, clk_dr, update_dr} !==
                {m_state == S_CAP_DR, m_state == S_SH_DR,
                 m_state == S_CAP_DR || m_state == S_SH_DR, m_state == S_UPD_DR}) begin
                errors++;
                $display("FAIL rand_strobes_%0d: got %b in state %h", i,
                         {capture_dr, shift_dr, clk_dr, update_dr}, m_state);
            end
            @(negedge tck);
            #1;
            checks++;
            if (tdo !== m_tdo || tdo_oe !== m_oe) begin
                errors++;
                $display("FAIL rand_tdo_%0d: tdo=%b oe=%b want %b %b", i, tdo, tdo_oe,
                         m_tdo, m_oe);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout reached, simulation still running");
        $fatal(1, "watchdog");
    end

    initial begin
        nx0[S_TLR] = S_RTI;       nx1[S_TLR] = S_TLR;
        nx0[S_RTI] = S_RTI;       nx1[S_RTI] = S_SEL_DR;
        nx0[S_SEL_DR] = S_CAP_DR; nx1[S_SEL_DR] = S_SEL_IR;
        nx0[S_SEL_IR] = S_CAP_IR; nx1[S_SEL_IR] = S_TLR;
        nx0[S_CAP_DR] = S_SH_DR;  nx1[S_CAP_DR] = S_EX1_DR;
        nx0[S_SH_DR] = S_SH_DR;   nx1[S_SH_DR] = S_EX1_DR;
        nx0[S_EX1_DR] = S_PA_DR;  nx1[S_EX1_DR] = S_UPD_DR;
        nx0[S_PA_DR] = S_PA_DR;   nx1[S_PA_DR] = S_EX2_DR;
        nx0[S_EX2_DR] = S_SH_DR;  nx1[S_EX2_DR] = S_UPD_DR;
        nx0[S_UPD_DR] = S_RTI;    nx1[S_UPD_DR] = S_SEL_DR;
        nx0[S_CAP_IR] = S_SH_IR;  nx1[S_CAP_IR] = S_EX1_IR;
        nx0[S_SH_IR] = S_SH_IR;   nx1[S_SH_IR] = S_EX1_IR;
        nx0[S_EX1_IR] = S_PA_IR;  nx1[S_EX1_IR] = S_UPD_IR;
        nx0[S_PA_IR] = S_PA_IR;   nx1[S_PA_IR] = S_EX2_IR;
        nx0[S_EX2_IR] = S_SH_IR;  nx1[S_EX2_IR] = S_UPD_IR;
        nx0[S_UPD_IR] = S_RTI;    nx1[S_UPD_IR] = S_SEL_DR;

        trstn  = 1'b0;
        tms    = 1'b1;
        tdi    = 1'b0;
        dr_sdo = 1'b0;
        #12;
        trstn = 1'b1;

        test_reset();
        test_ir_load();
        test_unknown_opcode();
        test_dr_scan();
        test_tms_reset();
        test_tlr_side_effect();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
